// File: rtl/chev3d_pkg.sv
// chev3d_pkg -- shared constants and helpers for the 3rd-order Chebyshev map.
//
// Contents:
//   FRAC_BITS            fractional bits of the Q1.30 input and Q2.30 output
//   X_W/OUT_W            state widths (input 32, output 33)
//   SQ_W/CU_W/SUM_W      overflow-free intermediate widths (34/36/38)
//   SAT_MAX/SAT_MIN      33-bit signed range limits, expressed at SUM_W
//   OUT_MAX/OUT_MIN      the same limits at OUT_W
//   sat33()              clamp a SUM_W value into the OUT_W signed range
package chev3d_pkg;

   localparam int FRAC_BITS = 30;

   localparam int X_W   = 32;
   localparam int OUT_W = 33;
   localparam int SQ_W  = 34;
   localparam int CU_W  = 36;
   localparam int SUM_W = 38;

   // +2^32-1 and -2^32 at the width of the final sum
   localparam logic signed [SUM_W-1:0] SAT_MAX = 38'sh00_FFFF_FFFF;
   localparam logic signed [SUM_W-1:0] SAT_MIN = 38'sh3F_0000_0000;

   // the same limits at the width of the output register
   localparam logic signed [OUT_W-1:0] OUT_MAX = 33'sh0_FFFF_FFFF;
   localparam logic signed [OUT_W-1:0] OUT_MIN = 33'sh1_0000_0000;

   // clamp the final sum into the representable output range
   function automatic logic signed [OUT_W-1:0] sat33(input logic signed [SUM_W-1:0] v);
      logic signed [OUT_W-1:0] r;
      if (v > SAT_MAX) begin
         r = OUT_MAX;
      end else if (v < SAT_MIN) begin
         r = OUT_MIN;
      end else begin
         r = v[OUT_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/chev3d_fxmul.sv
// chev3d_fxmul -- registered signed fixed-point multiply.
//
// Computes p = (a * b) >>> FRAC_BITS (floor, no rounding) and registers it.
// P_W must be large enough to hold the rescaled product without overflow;
// the discarded upper bits are pure sign copies for the operand ranges used.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-high (clears p)
//   a      signed multiplicand, A_W bits
//   b      signed multiplier,   B_W bits
//   p      registered rescaled product, P_W bits
module chev3d_fxmul #(
   parameter int A_W       = chev3d_pkg::X_W,
   parameter int B_W       = chev3d_pkg::X_W,
   parameter int P_W       = chev3d_pkg::SQ_W,
   parameter int FRAC_BITS = chev3d_pkg::FRAC_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic signed [A_W-1:0] a,
   input  logic signed [B_W-1:0] b,
   output logic signed [P_W-1:0] p
);

   logic signed [A_W+B_W-1:0] full_s;
   logic signed [A_W+B_W-1:0] shifted_s;

   // full-precision product, then floor-rescale by the fractional bit count
   always_comb begin
      full_s    = a * b;
      shifted_s = full_s >>> FRAC_BITS;
   end

   // output register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         p <= '0;
      end else begin
         p <= P_W'(shifted_s);
      end
   end

endmodule

// File: rtl/chev3d_map.sv
// chev3d_map -- 3-stage pipelined Chebyshev map x(t+1) = 4*x^3 - 3*x.
//
// A new Q1.30 sample is accepted every clock. Stage 1 forms x^2, stage 2
// forms x^3, stage 3 forms 4*x^3 - 3*x and saturates it to Q2.30.
// xt sampled on edge N is visible on xtn after edge N+2.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-high despite the name (1 = reset)
//   xt     signed Q1.30 current state, 32'h4000_0000 = +1.0
//   xtn    signed Q2.30 next state, registered, saturated to 33 bits
module chev3d_map #(
   parameter int FRAC_BITS = chev3d_pkg::FRAC_BITS
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic signed [chev3d_pkg::X_W-1:0]   xt,
   output logic signed [chev3d_pkg::OUT_W-1:0] xtn
);

   import chev3d_pkg::*;

   logic signed [X_W-1:0]   x1_r;
   logic signed [X_W-1:0]   x2_r;
   logic signed [SQ_W-1:0]  sq_r;
   logic signed [CU_W-1:0]  cu_r;
   logic signed [SUM_W-1:0] cu_ext_s;
   logic signed [SUM_W-1:0] x_ext_s;
   logic signed [SUM_W-1:0] sum_s;

   // stage 1 product: sq = x*x rescaled
   chev3d_fxmul #(
      .A_W      (X_W),
      .B_W      (X_W),
      .P_W      (SQ_W),
      .FRAC_BITS(FRAC_BITS)
   ) u_sq (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (xt),
      .b    (xt),
      .p    (sq_r)
   );

   // stage 2 product: cu = sq*x rescaled, x taken from the stage 1 copy
   chev3d_fxmul #(
      .A_W      (SQ_W),
      .B_W      (X_W),
      .P_W      (CU_W),
      .FRAC_BITS(FRAC_BITS)
   ) u_cu (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (sq_r),
      .b    (x1_r),
      .p    (cu_r)
   );

   // carry x alongside the products so each stage sees its own sample
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         x1_r <= '0;
         x2_r <= '0;
      end else begin
         x1_r <= xt;
         x2_r <= x1_r;
      end
   end

   // stage 3 arithmetic: 4*cu - 3*x at full width, 3*x as x + 2*x
   always_comb begin
      cu_ext_s = SUM_W'(cu_r);
      x_ext_s  = SUM_W'(x2_r);
      sum_s    = (cu_ext_s <<< 2) - (x_ext_s + (x_ext_s <<< 1));
   end

   // stage 3 register: saturated next state
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         xtn <= '0;
      end else begin
         xtn <= sat33(sum_s);
      end
   end

endmodule

// File: tb/tb_chev3d_map.sv
// tb_chev3d_map -- directed self-checking bench for chev3d_map.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_chev3d_map;

   logic               clk;
   logic               rst;
   logic signed [31:0] xt;
   logic signed [32:0] xtn;

   int checks;
   int failures;

   chev3d_map #(.FRAC_BITS(30)) dut (
      .clk  (clk),
      .rst_n(rst),
      .xt   (xt),
      .xtn  (xtn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reset asserted asynchronously, held, then released with xt = 0
   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if (xtn !== 33'sd0) begin
         failures++;
         $display("FAIL reset_async actual=%0d expected=0", xtn);
      end
      xt = 32'sh4000_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (xtn !== 33'sd0) begin
            failures++;
            $display("FAIL reset_hold cycle=%0d actual=%0d expected=0", i, xtn);
         end
      end
      xt  = 32'sd0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (xtn !== 33'sd0) begin
            failures++;
            $display("FAIL zero_after_release cycle=%0d actual=%0d expected=0", i, xtn);
         end
      end
   endtask

   // fixed points 0, +1.0, -1.0 with exact 3-edge latency
   task automatic test_fixed_points();
      logic signed [31:0] vin  [3] = '{32'sh4000_0000, 32'shC000_0000, 32'sd0};
      logic signed [32:0] vexp [3] = '{33'sd1073741824, -33'sd1073741824, 33'sd0};
      logic signed [32:0] prev;
      logic signed [32:0] want;
      prev = 33'sd0;
      for (int k = 0; k < 3; k++) begin
         xt = vin[k];
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            want = (c == 3) ? vexp[k] : prev;
            checks++;
            if (xtn !== want) begin
               failures++;
               $display("FAIL fixed_point xt=%0d cycle=%0d actual=%0d expected=%0d", vin[k], c, xtn, want);
            end
         end
         prev = vexp[k];
      end
   endtask

   // +/-0.5 map to -1.0 / +1.0
   task automatic test_half();
      logic signed [31:0] vin  [3] = '{32'sd536870912, -32'sd536870912, 32'sd0};
      logic signed [32:0] vexp [3] = '{-33'sd1073741824, 33'sd1073741824, 33'sd0};
      logic signed [32:0] prev;
      logic signed [32:0] want;
      prev = 33'sd0;
      for (int k = 0; k < 3; k++) begin
         xt = vin[k];
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            want = (c == 3) ? vexp[k] : prev;
            checks++;
            if (xtn !== want) begin
               failures++;
               $display("FAIL half xt=%0d cycle=%0d actual=%0d expected=%0d", vin[k], c, xtn, want);
            end
         end
         prev = vexp[k];
      end
   endtask

   // small inputs, including a negative one where floor gives cu = -1
   task automatic test_small();
      logic signed [31:0] vin  [5] = '{32'sd124, 32'sd1245, 32'sd53224, -32'sd53224, 32'sd0};
      logic signed [32:0] vexp [5] = '{-33'sd372, -33'sd3735, -33'sd159672, 33'sd159668, 33'sd0};
      logic signed [32:0] prev;
      logic signed [32:0] want;
      prev = 33'sd0;
      for (int k = 0; k < 5; k++) begin
         xt = vin[k];
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            want = (c == 3) ? vexp[k] : prev;
            checks++;
            if (xtn !== want) begin
               failures++;
               $display("FAIL small xt=%0d cycle=%0d actual=%0d expected=%0d", vin[k], c, xtn, want);
            end
         end
         prev = vexp[k];
      end
   endtask

   // both saturation limits
   task automatic test_saturation();
      logic signed [31:0] vin  [3] = '{32'sh8000_0000, 32'sh7FFF_FFFF, 32'sd0};
      logic signed [32:0] vexp [3] = '{33'sh1_0000_0000, 33'sh0_FFFF_FFFF, 33'sd0};
      logic signed [32:0] prev;
      logic signed [32:0] want;
      prev = 33'sd0;
      for (int k = 0; k < 3; k++) begin
         xt = vin[k];
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            want = (c == 3) ? vexp[k] : prev;
            checks++;
            if (xtn !== want) begin
               failures++;
               $display("FAIL saturation xt=%0d cycle=%0d actual=%0h expected=%0h", vin[k], c, xtn, want);
            end
         end
         prev = vexp[k];
      end
   endtask

   // new sample every cycle, outputs in order three edges later
   task automatic test_back_to_back();
      logic signed [31:0] vin  [10] = '{32'sh4000_0000, 32'shC000_0000, 32'sd536870912,
                                        -32'sd536870912, 32'sd124, 32'sd1245, 32'sd53224,
                                        -32'sd53224, 32'sh8000_0000, 32'sh7FFF_FFFF};
      logic signed [32:0] vexp [10] = '{33'sd1073741824, -33'sd1073741824, -33'sd1073741824,
                                        33'sd1073741824, -33'sd372, -33'sd3735, -33'sd159672,
                                        33'sd159668, 33'sh1_0000_0000, 33'sh0_FFFF_FFFF};
      logic signed [32:0] want;
      for (int i = 0; i < 13; i++) begin
         want = (i >= 3) ? vexp[i-3] : 33'sd0;
         checks++;
         if (xtn !== want) begin
            failures++;
            $display("FAIL back_to_back slot=%0d actual=%0d expected=%0d", i, xtn, want);
         end
         xt = (i < 10) ? vin[i] : 32'sd0;
         @(negedge clk);
      end
   endtask

   // reset mid-stream zeroes xtn at once and flushes the pipeline
   task automatic test_mid_reset();
      logic signed [31:0] vin [4] = '{32'sh4000_0000, 32'sd536870912, 32'shC000_0000, 32'sd124};
      logic signed [32:0] want;
      for (int i = 0; i < 4; i++) begin
         xt = vin[i];
         @(negedge clk);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (xtn !== 33'sd0) begin
         failures++;
         $display("FAIL mid_reset_async actual=%0d expected=0", xtn);
      end
      xt = 32'sd1245;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (xtn !== 33'sd0) begin
         failures++;
         $display("FAIL mid_reset_hold actual=%0d expected=0", xtn);
      end
      rst = 1'b0;
      xt  = 32'sd536870912;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         want = (c == 3) ? -33'sd1073741824 : 33'sd0;
         checks++;
         if (xtn !== want) begin
            failures++;
            $display("FAIL mid_reset_flush cycle=%0d actual=%0d expected=%0d", c, xtn, want);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      xt       = 32'sd0;
      test_reset();
      test_fixed_points();
      test_half();
      test_small();
      test_saturation();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // bound the whole run
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1);
   end

endmodule
